uart_tx_fifo_engine: RTL and testbench

Parametrised serial transmit engine with an internal write FIFO. Bytes written by the processor-side port are queued, then serialised LSB-first as asynchronous frames on tx. Frame format is runtime-selectable: 5–8 data bits, none/even/odd parity, and 1 or 2 stop bits. Bit time comes from a runtime divisor. The block sits between the I/O write decode and the serial pin, and supports multi-byte bursts without per-byte polling.

---
 rtl/uart_tx_fifo_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo_engine.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_engine.sv
// Serial transmit engine with a write FIFO. Queued bytes are sent LSB-first as async frames.
// The frame format and bit time are captured from the inputs when each byte is loaded.
module uart_tx_fifo_engine #(
   parameter int FIFO_DEPTH = 4,
   parameter int K_W        = 19,
   parameter int CNT_W      = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [7:0]       wr_data,
   input  logic [1:0]       word_len,
   input  logic             pen,
   input  logic             odd,
   input  logic             two_stop,
   input  logic [K_W-1:0]   baud_k,
   output logic             tx,
   output logic             tx_rdy,
   output logic             busy,
   output logic [CNT_W-1:0] fifo_count,
   output logic             tx_done,
   output logic             overflow
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_e;

   function automatic logic frame_parity(input logic [7:0] data, input logic [1:0] wl,
                                         input logic odd_sel);
      logic [7:0] mask;
      case (wl)
         2'b00:   mask = 8'h1F;
         2'b01:   mask = 8'h3F;
         2'b10:   mask = 8'h7F;
         default: mask = 8'hFF;
      endcase
      return (^(data & mask)) ^ odd_sel;
   endfunction

   // A divisor of 0 behaves like 1 so a bit never takes zero clocks.
   function automatic logic [K_W-1:0] bit_clocks(input logic [K_W-1:0] k);
      logic [K_W-1:0] r;
      if (k == {K_W{1'b0}}) begin
         r = {{(K_W-1){1'b0}}, 1'b1};
      end else begin
         r = k;
      end
      return r;
   endfunction

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q;
   logic             empty_s, full_s, push_s, pop_s;

   state_e           state_q, state_d;
   logic [K_W-1:0]   cnt_q, cnt_d, k_q, k_d, k_eff_s, k_eff_d;
   logic [2:0]       bit_q, bit_d;
   logic             stop_q, stop_d;
   logic [7:0]       data_q, data_d;
   logic [1:0]       wl_q, wl_d;
   logic             pen_q, pen_d, odd_q, odd_d, two_q, two_d;
   logic             tx_q, tx_d, busy_q, busy_d, done_q, done_d;
   logic             bit_end_s, frame_end_s;

   assign empty_s    = (count_q == {CNT_W{1'b0}});
   assign full_s     = (count_q == CNT_W'(FIFO_DEPTH));
   assign push_s     = wr_en && (!full_s || pop_s);
   assign tx_rdy     = (count_q < CNT_W'(FIFO_DEPTH));
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign tx_done    = done_q;

   // FIFO occupancy bookkeeping.
   always_comb begin
      count_d = count_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
         default: count_d = count_q;
      endcase
   end

   // FIFO storage, pointers and the dropped-write pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
         wr_ptr_q   <= {PTR_W{1'b0}};
         rd_ptr_q   <= {PTR_W{1'b0}};
         count_q    <= {CNT_W{1'b0}};
         overflow_q <= 1'b0;
      end else begin
         if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
            wr_ptr_q        <= wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         count_q    <= count_d;
         overflow_q <= wr_en && !push_s;
      end
   end

   assign k_eff_s     = bit_clocks(k_q);
   assign bit_end_s   = (cnt_q == k_eff_s - {{(K_W-1){1'b0}}, 1'b1});
   assign frame_end_s = (state_q == S_STOP) && bit_end_s && (stop_q == two_q);
   assign pop_s       = !empty_s && ((state_q == S_IDLE) || frame_end_s);

   // Frame sequencing; outputs are derived from the next state so they register in step with it.
   always_comb begin
      state_d = state_q;
      cnt_d   = bit_end_s ? {K_W{1'b0}} : cnt_q + {{(K_W-1){1'b0}}, 1'b1};
      bit_d   = bit_q;
      stop_d  = stop_q;
      data_d  = data_q;
      wl_d    = wl_q;
      pen_d   = pen_q;
      odd_d   = odd_q;
      two_d   = two_q;
      k_d     = k_q;
      case (state_q)
         S_IDLE: begin
            cnt_d   = {K_W{1'b0}};
            state_d = empty_s ? S_IDLE : S_START;
         end
         S_START: begin
            if (bit_end_s) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
            end else begin
               state_d = S_START;
            end
         end
         S_DATA: begin
            if (bit_end_s && (bit_q == ({1'b0, wl_q} + 3'd4))) begin
               state_d = pen_q ? S_PARITY : S_STOP;
               stop_d  = 1'b0;
            end else if (bit_end_s) begin
               bit_d = bit_q + 3'd1;
            end else begin
               state_d = S_DATA;
            end
         end
         S_PARITY: begin
            if (bit_end_s) begin
               state_d = S_STOP;
               stop_d  = 1'b0;
            end else begin
               state_d = S_PARITY;
            end
         end
         S_STOP: begin
            if (frame_end_s) begin
               state_d = empty_s ? S_IDLE : S_START;
            end else if (bit_end_s) begin
               stop_d = 1'b1;
            end else begin
               state_d = S_STOP;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (pop_s) begin
         data_d = mem_q[rd_ptr_q];
         wl_d   = word_len;
         pen_d  = pen;
         odd_d  = odd;
         two_d  = two_stop;
         k_d    = baud_k;
         cnt_d  = {K_W{1'b0}};
      end else begin
         data_d = data_d;
      end

      k_eff_d = bit_clocks(k_d);
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = data_d[bit_d];
         S_PARITY: tx_d = frame_parity(data_d, wl_d, odd_d);
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_STOP) && (stop_d == two_d) &&
               (cnt_d == k_eff_d - {{(K_W-1){1'b0}}, 1'b1});
   end

   // Frame state, latched configuration and registered line outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= {K_W{1'b0}};
         bit_q   <= 3'd0;
         stop_q  <= 1'b0;
         data_q  <= 8'h00;
         wl_q    <= 2'b00;
         pen_q   <= 1'b0;
         odd_q   <= 1'b0;
         two_q   <= 1'b0;
         k_q     <= {K_W{1'b0}};
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         data_q  <= data_d;
         wl_q    <= wl_d;
         pen_q   <= pen_d;
         odd_q   <= odd_d;
         two_q   <= two_d;
         k_q     <= k_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// Bench for uart_tx_fifo_engine: directed and random writes checked each clock against
// a queue-based model that expands every popped byte into its per-clock line samples.
module tb_uart_tx_fifo_engine;
   localparam int DEPTH = 4;
   localparam int KW    = 19;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic [1:0]    word_len;
   logic          pen, odd, two_stop;
   logic [KW-1:0] baud_k;
   logic          tx, tx_rdy, busy, tx_done, overflow;
   logic [CW-1:0] fifo_count;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   done_cnt, ovf_cnt;
   logic [7:0] fq[$];
   bit   line[$];
   bit   exp_ovf;

   uart_tx_fifo_engine #(.FIFO_DEPTH(DEPTH), .K_W(KW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .word_len(word_len),
      .pen(pen), .odd(odd), .two_stop(two_stop), .baud_k(baud_k), .tx(tx),
      .tx_rdy(tx_rdy), .busy(busy), .fifo_count(fifo_count), .tx_done(tx_done),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expand one byte into the line level for every clock of its frame.
   task automatic build_frame(input logic [7:0] d);
      int kk;
      int n;
      bit par;
      bit bits[$];
      kk  = (baud_k <= 19'd1) ? 1 : int'(baud_k);
      n   = int'(word_len) + 5;
      par = odd;
      bits.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         bits.push_back(d[i]);
         par ^= d[i];
      end
      if (pen) bits.push_back(par);
      bits.push_back(1'b1);
      if (two_stop) bits.push_back(1'b1);
      foreach (bits[j]) repeat (kk) line.push_back(bits[j]);
   endtask

   task automatic model_edge();
      if (line.size() > 0) void'(line.pop_front());
      if (line.size() == 0 && fq.size() > 0) build_frame(fq.pop_front());
      exp_ovf = 1'b0;
      if (wr_en) begin
         if (fq.size() < DEPTH) fq.push_back(wr_data);
         else exp_ovf = 1'b1;
      end
   endtask

   task automatic check_outputs();
      check("tx", 32'(tx), 32'((line.size() > 0) ? line[0] : 1'b1));
      check("busy", 32'(busy), 32'(line.size() > 0));
      check("tx_done", 32'(tx_done), 32'(line.size() == 1));
      check("fifo_count", 32'(fifo_count), 32'(fq.size()));
      check("tx_rdy", 32'(tx_rdy), 32'(fq.size() < DEPTH));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      if (tx_done) done_cnt++;
      if (overflow) ovf_cnt++;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
      wr_en = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      cycle();
   endtask

   task automatic set_cfg(input logic [1:0] wl, input logic p, input logic o,
                          input logic ts, input int k);
      word_len = wl;
      pen      = p;
      odd      = o;
      two_stop = ts;
      baud_k   = KW'(k);
   endtask

   initial begin
      rst = 1'b1;
      wr_en = 1'b0;
      wr_data = 8'h00;
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 4);
      exp_ovf = 1'b0;
      done_cnt = 0;
      ovf_cnt = 0;
      #12;
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_tx_rdy", 32'(tx_rdy), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_done", 32'(tx_done), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cycle();

      // 8N1 at 4 clocks/bit
      done_cnt = 0;
      write_byte(8'h55);
      repeat (45) cycle();
      check("t1_done_pulses", 32'(done_cnt), 32'd1);

      // 7E1 at 3 clocks/bit
      set_cfg(2'b10, 1'b1, 1'b0, 1'b0, 3);
      done_cnt = 0;
      write_byte(8'h41);
      repeat (35) cycle();
      check("t2_done_pulses", 32'(done_cnt), 32'd1);

      // 5O2 at 2 clocks/bit
      set_cfg(2'b00, 1'b1, 1'b1, 1'b1, 2);
      done_cnt = 0;
      write_byte(8'h13);
      repeat (22) cycle();
      check("t3_done_pulses", 32'(done_cnt), 32'd1);

      // burst of six into a four-deep FIFO
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1);
      done_cnt = 0;
      ovf_cnt = 0;
      for (int i = 0; i < 6; i++) write_byte(8'hA0 + 8'(i));
      repeat (60) cycle();
      check("t4_done_pulses", 32'(done_cnt), 32'd5);
      check("t4_ovf_pulses", 32'(ovf_cnt), 32'd1);

      // reset in the middle of a data bit with a byte still queued
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 4);
      write_byte(8'hC3);
      write_byte(8'h3C);
      repeat (12) cycle();
      #2 rst = 1'b1;
      #1;
      check("t5_tx", 32'(tx), 32'd1);
      check("t5_count", 32'(fifo_count), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      line.delete();
      fq.delete();
      exp_ovf = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      repeat (30) cycle();
      check("t5_idle_done", 32'(done_cnt), 32'd0);
      write_byte(8'h81);
      repeat (45) cycle();
      check("t5_after_done", 32'(done_cnt), 32'd1);

      // reconfigure while the first of two queued frames is on the line
      done_cnt = 0;
      write_byte(8'hF0);
      write_byte(8'h0F);
      repeat (10) cycle();
      set_cfg(2'b00, 1'b0, 1'b0, 1'b0, 8);
      repeat (110) cycle();
      check("t6_done_pulses", 32'(done_cnt), 32'd2);

      // random writes with the frame format changing at random times
      for (int c = 0; c < 2500; c++) begin
         if (($urandom % 50) == 0)
            set_cfg(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)));
         if (($urandom % 4) == 0) begin
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
         end
         cycle();
      end
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1);
      repeat (300) cycle();
      check("drain_idle_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
